platform_reset_seq: RTL and testbench
=====================================

Name: platform_reset_seq

Overview:
- Reset sequencer between the board clock/PLL and the fpg_eye platform.
- Replaces the direct PLL-LOCK-to-reset connection with a filtered, staged release:
  - core platform first, then peripherals (SDRAM/SPI/I2C side), then camera power-up and reset.
- Detects PLL lock loss and re-runs the sequence. Exposes status for the GPIO block.

Parameters:
- LOCK_FILT_CYCLES, 16: consecutive synchronised lock-high samples required before HOLD.
- HOLD_CYCLES, 1024: cycles all resets stay asserted after lock is qualified.
- STAGE_GAP, 256: cycles between core release and peripheral release, and between peripheral release and camera power-up.
- CAM_GAP, 512: cycles camera is powered but still held in reset.
- LOSS_FILT, 2: consecutive lock-low samples that count as lock loss.

Ports:
- clk_i, input, 1: free-running board oscillator clock (25 MHz), not the PLL output.
- reset_n, input, 1: synchronous, active-low reset.
- pll_lock_i, input, 1: PLL LOCK, asynchronous; synchronised internally.
- soft_rst_i, input, 1: single-cycle request to re-run the sequence from HOLD.
- platform_reset_n_o, output, 1: core platform reset, active-low.
- periph_reset_n_o, output, 1: peripheral reset, active-low.
- cam_pwdn_o, output, 1: camera power-down, active-high.
- cam_rst_n_o, output, 1: camera reset, active-low.
- seq_done_o, output, 1: high only in RUN.
- seq_state_o, output, 3: current state encoding.
- relock_cnt_o, output, 8: saturating count of lock-loss events.

Behaviour:
- Reset:
  - reset_n low at a clk_i edge puts the state in IDLE and clears all counters and relock_cnt_o.
  - Outputs during reset: platform_reset_n_o=0, periph_reset_n_o=0, cam_pwdn_o=1, cam_rst_n_o=0, seq_done_o=0.
  - reset_n low mid-sequence aborts on the next edge.
- Synchronisation: pll_lock_i passes through a 2-flop synchroniser; all lock decisions use the synchronised value (lock_s).
- Outputs are registered decodes of state and change on the same edge the state changes.
- Counter: one shared counter, width clog2 of the largest parameter plus 1. It clears to 0 on every state entry.
- States and transitions:
  - IDLE: all asserted. Goes to WAIT_LOCK unconditionally on the next cycle.
  - WAIT_LOCK: all asserted.
    - Filter count increments while lock_s=1 and clears on any lock_s=0.
    - Reaching LOCK_FILT_CYCLES goes to HOLD.
  - HOLD: all asserted. Goes to CORE_UP after HOLD_CYCLES cycles.
  - CORE_UP: platform_reset_n_o=1. Goes to PERIPH_UP after STAGE_GAP cycles.
  - PERIPH_UP: adds periph_reset_n_o=1. Goes to CAM_PWR after STAGE_GAP cycles.
  - CAM_PWR: adds cam_pwdn_o=0; cam_rst_n_o stays 0. Goes to RUN after CAM_GAP cycles.
  - RUN: cam_rst_n_o=1, seq_done_o=1. Stays until one of the events below.
- Lock loss:
  - Trigger: in HOLD through RUN, lock_s=0 for LOSS_FILT consecutive cycles.
  - Result: next state is WAIT_LOCK, all outputs re-asserted on that edge, relock_cnt_o increments (saturates at 255).
  - A single-cycle low (shorter than LOSS_FILT) is ignored and stage timing is not disturbed.
- soft_rst_i:
  - In CORE_UP through RUN it goes to HOLD (all asserted) without re-qualifying lock.
  - Ignored in IDLE, WAIT_LOCK and HOLD.
  - relock_cnt_o is not incremented.
- Simultaneous events: lock-loss detection and soft_rst_i in the same cycle go to WAIT_LOCK (lock loss wins); relock_cnt_o increments.
- Clock domains: outputs are quasi-static levels. Consuming clock domains apply their own release synchronisers; that is outside this block.
- seq_state_o encoding: IDLE=0, WAIT_LOCK=1, HOLD=2, CORE_UP=3, PERIPH_UP=4, CAM_PWR=5, RUN=6.

Decomposition:
- Shared package platform_reset_pkg:
  - state enum and encoding constants;
  - output polarity constants (RST_ASSERT_N=0, PWDN_ASSERT=1);
  - counter-width function.
- Sub-module sync_2ff, a generic 2-flop level synchroniser, instantiated for pll_lock_i.
- The FSM, shared counter and loss filter stay in platform_reset_seq.

Test Plan:
All scenarios use parameters LOCK_FILT_CYCLES=4, HOLD_CYCLES=8, STAGE_GAP=4, CAM_GAP=4, LOSS_FILT=2.
1. Power-up. reset_n low 5 cycles, then high; pll_lock_i held high.
   - Before HOLD: all outputs in their asserted state.
   - Relative to the first HOLD cycle: platform_reset_n_o rises at +8, periph_reset_n_o at +12, cam_pwdn_o falls at +16, cam_rst_n_o and seq_done_o rise at +20.
   - seq_state_o walks 0→1→2→3→4→5→6.
2. Lock bounce in WAIT_LOCK. lock pattern 1,1,1,0,1,1,1,1 → no HOLD until 4 consecutive high synchronised samples; filter count restarts after the 0.
3. Glitch in RUN. pll_lock_i low for 1 cycle → state stays RUN, outputs unchanged, relock_cnt_o=0.
4. Lock loss in RUN. pll_lock_i low for 3 cycles, then high.
   - After 2 synchronised lows: all outputs asserted, seq_state_o=1, relock_cnt_o=1.
   - Full sequence then repeats with the timing of scenario 1.
5. Soft reset and priority.
   - soft_rst_i pulse in PERIPH_UP → HOLD next cycle, all asserted, relock_cnt_o unchanged, release resumes after 8 cycles.
   - soft_rst_i coinciding with lock-loss detection → WAIT_LOCK, relock_cnt_o increments.
6. Reset mid-sequence and saturation.
   - reset_n low during CAM_PWR → IDLE on the next edge, cam_pwdn_o=1, relock_cnt_o=0.
   - 300 forced lock-loss events → relock_cnt_o holds at 255.

Source files
------------

// File: rtl/platform_reset_pkg.sv
// Shared types and constants for the platform reset sequencer.
package platform_reset_pkg;

   localparam int unsigned STATE_W  = 3;
   localparam int unsigned RELOCK_W = 8;

   localparam logic RST_ASSERT_N = 1'b0;
   localparam logic PWDN_ASSERT  = 1'b1;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_HOLD      = 3'd2,
      ST_CORE_UP   = 3'd3,
      ST_PERIPH_UP = 3'd4,
      ST_CAM_PWR   = 3'd5,
      ST_RUN       = 3'd6
   } seq_state_t;

   // Counter width able to hold max_val, plus one bit of headroom.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val) + 1;
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/platform_reset_seq_sync_2ff.sv
// Generic two-flop level synchroniser with synchronous active-low reset.
module sync_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/platform_reset_seq.sv
// Staged reset release for the platform: core, peripherals, then camera.
// Re-runs the sequence on filtered PLL lock loss or a soft reset request.
module platform_reset_seq #(
   parameter int unsigned LOCK_FILT_CYCLES = 16,
   parameter int unsigned HOLD_CYCLES      = 1024,
   parameter int unsigned STAGE_GAP        = 256,
   parameter int unsigned CAM_GAP          = 512,
   parameter int unsigned LOSS_FILT        = 2
) (
   input  logic       clk_i,
   input  logic       reset_n,
   input  logic       pll_lock_i,
   input  logic       soft_rst_i,
   output logic       platform_reset_n_o,
   output logic       periph_reset_n_o,
   output logic       cam_pwdn_o,
   output logic       cam_rst_n_o,
   output logic       seq_done_o,
   output logic [2:0] seq_state_o,
   output logic [7:0] relock_cnt_o
);

   import platform_reset_pkg::*;

   localparam int unsigned MAX_P  = max2(max2(max2(LOCK_FILT_CYCLES, HOLD_CYCLES),
                                              max2(STAGE_GAP, CAM_GAP)), LOSS_FILT);
   localparam int unsigned CNT_W  = cnt_width(MAX_P);
   localparam int unsigned LOSS_W = cnt_width(LOSS_FILT);

   seq_state_t          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [LOSS_W-1:0]   loss_q, loss_d;
   logic [RELOCK_W-1:0] relock_q, relock_d;
   logic                lock_s;
   logic                lock_lost;
   logic                plat_d, periph_d, pwdn_d, camrst_d, done_d;

   sync_2ff u_lock_sync (
      .clk     (clk_i),
      .reset_n (reset_n),
      .d       (pll_lock_i),
      .q       (lock_s)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_n) begin
         state_q            <= ST_IDLE;
         cnt_q              <= '0;
         loss_q             <= '0;
         relock_q           <= '0;
         platform_reset_n_o <= RST_ASSERT_N;
         periph_reset_n_o   <= RST_ASSERT_N;
         cam_pwdn_o         <= PWDN_ASSERT;
         cam_rst_n_o        <= RST_ASSERT_N;
         seq_done_o         <= 1'b0;
      end else begin
         state_q            <= state_d;
         cnt_q              <= cnt_d;
         loss_q             <= loss_d;
         relock_q           <= relock_d;
         platform_reset_n_o <= plat_d;
         periph_reset_n_o   <= periph_d;
         cam_pwdn_o         <= pwdn_d;
         cam_rst_n_o        <= camrst_d;
         seq_done_o         <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      loss_d    = '0;
      relock_d  = relock_q;
      lock_lost = 1'b0;

      // Lock-low filter only runs once lock has been qualified.
      if ((state_q inside {ST_HOLD, ST_CORE_UP, ST_PERIPH_UP, ST_CAM_PWR, ST_RUN}) && !lock_s) begin
         if (loss_q == LOSS_W'(LOSS_FILT - 1)) lock_lost = 1'b1;
         else                                  loss_d    = loss_q + LOSS_W'(1);
      end

      case (state_q)
         ST_IDLE:      state_d = ST_WAIT_LOCK;
         ST_WAIT_LOCK: if (lock_s && cnt_q == CNT_W'(LOCK_FILT_CYCLES - 1)) state_d = ST_HOLD;
         ST_HOLD:      if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = ST_CORE_UP;
         ST_CORE_UP:   if (cnt_q == CNT_W'(STAGE_GAP - 1))   state_d = ST_PERIPH_UP;
         ST_PERIPH_UP: if (cnt_q == CNT_W'(STAGE_GAP - 1))   state_d = ST_CAM_PWR;
         ST_CAM_PWR:   if (cnt_q == CNT_W'(CAM_GAP - 1))     state_d = ST_RUN;
         ST_RUN:       state_d = ST_RUN;
         default:      state_d = ST_IDLE;
      endcase

      if (soft_rst_i && (state_q inside {ST_CORE_UP, ST_PERIPH_UP, ST_CAM_PWR, ST_RUN}))
         state_d = ST_HOLD;

      // Lock loss overrides every other transition, including soft reset.
      if (lock_lost) begin
         state_d = ST_WAIT_LOCK;
         if (relock_q != '1) relock_d = relock_q + RELOCK_W'(1);
      end

      if (state_d != state_q)
         cnt_d = '0;
      else if (state_q == ST_WAIT_LOCK)
         cnt_d = lock_s ? cnt_q + CNT_W'(1) : '0;
      else if (state_q inside {ST_HOLD, ST_CORE_UP, ST_PERIPH_UP, ST_CAM_PWR})
         cnt_d = cnt_q + CNT_W'(1);

      plat_d   = (state_d inside {ST_CORE_UP, ST_PERIPH_UP, ST_CAM_PWR, ST_RUN})
                 ? ~RST_ASSERT_N : RST_ASSERT_N;
      periph_d = (state_d inside {ST_PERIPH_UP, ST_CAM_PWR, ST_RUN})
                 ? ~RST_ASSERT_N : RST_ASSERT_N;
      pwdn_d   = (state_d inside {ST_CAM_PWR, ST_RUN}) ? ~PWDN_ASSERT : PWDN_ASSERT;
      camrst_d = (state_d == ST_RUN) ? ~RST_ASSERT_N : RST_ASSERT_N;
      done_d   = (state_d == ST_RUN);
   end

   assign seq_state_o  = state_q;
   assign relock_cnt_o = relock_q;

endmodule

// File: tb/tb_platform_reset_seq.sv
// Randomised and directed bench for platform_reset_seq against a timeline model.
module tb_platform_reset_seq;

   localparam int LF   = 4;
   localparam int HOLD = 8;
   localparam int GAP  = 4;
   localparam int CAMG = 4;
   localparam int LOSS = 2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       pll_lock_i;
   logic       soft_rst_i;
   logic       platform_reset_n_o;
   logic       periph_reset_n_o;
   logic       cam_pwdn_o;
   logic       cam_rst_n_o;
   logic       seq_done_o;
   logic [2:0] seq_state_o;
   logic [7:0] relock_cnt_o;

   int total = 0;
   int bad   = 0;

   // Model: phase 0=idle, 1=waiting for lock, 2=sequencing (elapsed cycles m_e since HOLD entry)
   int m_phase, m_hi, m_lo, m_e, m_relock;
   bit m_sync0, m_sync1;

   always #5 clk = ~clk;

   platform_reset_seq #(
      .LOCK_FILT_CYCLES (LF),
      .HOLD_CYCLES      (HOLD),
      .STAGE_GAP        (GAP),
      .CAM_GAP          (CAMG),
      .LOSS_FILT        (LOSS)
   ) dut (
      .clk_i              (clk),
      .reset_n            (reset_n),
      .pll_lock_i         (pll_lock_i),
      .soft_rst_i         (soft_rst_i),
      .platform_reset_n_o (platform_reset_n_o),
      .periph_reset_n_o   (periph_reset_n_o),
      .cam_pwdn_o         (cam_pwdn_o),
      .cam_rst_n_o        (cam_rst_n_o),
      .seq_done_o         (seq_done_o),
      .seq_state_o        (seq_state_o),
      .relock_cnt_o       (relock_cnt_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   function automatic int exp_state();
      if (m_phase == 0) return 0;
      if (m_phase == 1) return 1;
      if (m_e < HOLD)                  return 2;
      if (m_e < HOLD + GAP)            return 3;
      if (m_e < HOLD + 2*GAP)          return 4;
      if (m_e < HOLD + 2*GAP + CAMG)   return 5;
      return 6;
   endfunction

   // {platform_reset_n, periph_reset_n, cam_pwdn, cam_rst_n, seq_done}
   function automatic logic [4:0] exp_outs();
      int st;
      st = exp_state();
      return {st >= 3, st >= 4, st < 5, st == 6, st == 6};
   endfunction

   task automatic model_step(input bit r, input bit l, input bit s);
      bit ls;
      if (!r) begin
         m_phase = 0; m_hi = 0; m_lo = 0; m_e = 0; m_relock = 0;
         m_sync0 = 0; m_sync1 = 0;
      end else begin
         ls = m_sync1;
         case (m_phase)
            0: begin m_phase = 1; m_hi = 0; end
            1: begin
               m_hi = ls ? m_hi + 1 : 0;
               if (m_hi == LF) begin m_phase = 2; m_e = 0; m_lo = 0; end
            end
            default: begin
               m_lo = ls ? 0 : m_lo + 1;
               if (m_lo == LOSS) begin
                  m_phase = 1; m_hi = 0; m_lo = 0;
                  if (m_relock < 255) m_relock++;
               end else if (s && m_e >= HOLD) m_e = 0;
               else if (m_e < 1000) m_e++;
            end
         endcase
         m_sync1 = m_sync0;
         m_sync0 = l;
      end
   endtask

   task automatic cyc(input bit r, input bit l, input bit s);
      reset_n    = r;
      pll_lock_i = l;
      soft_rst_i = s;
      @(posedge clk);
      model_step(r, l, s);
      @(negedge clk);
      check("state",  32'(seq_state_o), 32'(exp_state()));
      check("outs",   32'({platform_reset_n_o, periph_reset_n_o, cam_pwdn_o,
                           cam_rst_n_o, seq_done_o}), 32'(exp_outs()));
      check("relock", 32'(relock_cnt_o), 32'(m_relock));
   endtask

   task automatic run_to_state(input string tag, input int st);
      int n = 0;
      while (exp_state() != st && n < 200) begin
         cyc(1, 1, 0);
         n++;
      end
      if (exp_state() != st) check(tag, 32'(exp_state()), 32'(st));
   endtask

   task automatic lose_lock(input string tag);
      int n = 0;
      while (m_phase != 1 && n < 20) begin
         cyc(1, 0, 0);
         n++;
      end
      if (m_phase != 1) check(tag, 32'(m_phase), 32'd1);
   endtask

   task automatic do_reset();
      repeat (5) cyc(0, 1, 0);
   endtask

   initial begin
      reset_n = 1'b0; pll_lock_i = 1'b0; soft_rst_i = 1'b0;
      m_phase = 0; m_hi = 0; m_lo = 0; m_e = 0; m_relock = 0;
      m_sync0 = 0; m_sync1 = 0;
      @(negedge clk);

      // Power-up with lock steady
      do_reset();
      check("rst_state", 32'(seq_state_o), 32'd0);
      check("rst_pwdn",  32'(cam_pwdn_o), 32'd1);
      repeat (30) cyc(1, 1, 0);
      check("pwrup_done", 32'(seq_done_o), 32'd1);

      // Lock bounce while waiting
      do_reset();
      cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 0, 0);
      repeat (30) cyc(1, 1, 0);

      // Single-cycle glitch in RUN
      cyc(1, 0, 0);
      repeat (10) cyc(1, 1, 0);
      check("glitch_relock", 32'(relock_cnt_o), 32'd0);
      check("glitch_state",  32'(seq_state_o), 32'd6);

      // Lock loss in RUN, then full re-sequence
      repeat (3) cyc(1, 0, 0);
      repeat (30) cyc(1, 1, 0);
      check("loss_relock", 32'(relock_cnt_o), 32'd1);

      // Soft reset in PERIPH_UP, then soft reset coinciding with loss detection
      do_reset();
      run_to_state("to_periph", 4);
      cyc(1, 1, 1);
      check("soft_hold", 32'(seq_state_o), 32'd2);
      repeat (30) cyc(1, 1, 0);
      cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 1);
      check("prio_state",  32'(seq_state_o), 32'd1);
      check("prio_relock", 32'(relock_cnt_o), 32'd1);
      repeat (10) cyc(1, 1, 0);

      // Reset mid-sequence
      run_to_state("to_cam", 5);
      cyc(0, 1, 0);
      check("mid_rst_pwdn",   32'(cam_pwdn_o), 32'd1);
      check("mid_rst_relock", 32'(relock_cnt_o), 32'd0);

      // Relock counter saturation
      for (int i = 0; i < 300; i++) begin
         run_to_state("sat_hold", 2);
         lose_lock("sat_loss");
      end
      check("sat_relock", 32'(relock_cnt_o), 32'd255);

      // Random stimulus
      for (int i = 0; i < 3000; i++)
         cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 15) != 0),
             ($urandom_range(0, 31) == 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
